status_state_gen: RTL and testbench
===================================

Name: status_state_gen

Overview:
Generates the 2-bit status code that drives the board's LED status indicator, which renders 0/1/2 as single/double/triple blink and 3 as solid on. Sits between the command/UART front end and the switch actuator on one side, and the LED indicator on the other. It turns short event pulses and the actuator busy level into a stable, priority-encoded status, using tick-based hold timers so brief events stay visible on the LED.

Parameters:
TICK_DIV, 16'd50000, clock cycles per timer tick (1 ms at 50 MHz); legal range 1..65535.
LINK_TIMEOUT, 12'd2000, ticks of link activity shown after the last received byte or command.
BUSY_HOLD, 12'd200, minimum ticks that busy stays displayed after sw_busy falls.
FAULT_HOLD, 12'd3000, ticks that fault stays displayed after a command error.

Ports:
Clk  in  1  system clock; all logic is on the rising edge.
Rst  in  1  asynchronous, active-high reset.
rx_activity  in  1  one-cycle pulse per received UART byte.
cmd_ok  in  1  one-cycle pulse per valid parsed command.
cmd_err  in  1  one-cycle pulse per malformed or rejected command.
sw_busy  in  1  level; high while a switch actuation is in progress.
clr_fault  in  1  one-cycle pulse that clears the fault display and the fault count.
state  out  2  status code to the LED indicator: 0 idle, 1 link active, 2 switching, 3 fault.
fault_cnt  out  8  saturating count of cmd_err pulses.
state_chg  out  1  one-cycle pulse when state changes value.

Behaviour:
- Reset is asynchronous. While Rst is high:
  - prescaler, link_tmr, busy_tmr and fault_tmr are all 0;
  - state=0, fault_cnt=0, state_chg=0.
  - Outputs take these values immediately, with no clock edge needed.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps to 0;
  - internal tick is high for one cycle when the count equals TICK_DIV-1;
  - with TICK_DIV=1, tick is high every cycle.
- Timers are 12-bit. Per timer, per cycle, in priority order: load > decrement-on-tick-if-nonzero > hold. A timer never wraps below 0.
- link_tmr:
  - loads LINK_TIMEOUT on rx_activity | cmd_ok | cmd_err;
  - link_up = (link_tmr != 0).
- busy_tmr:
  - loads BUSY_HOLD every cycle sw_busy is high;
  - decrements on tick only while sw_busy is low;
  - busy_disp = sw_busy | (busy_tmr != 0).
- fault_tmr:
  - loads FAULT_HOLD on cmd_err;
  - on clr_fault without cmd_err, clears to 0;
  - on cmd_err and clr_fault in the same cycle, loads FAULT_HOLD.
- fault_cnt:
  - on cmd_err, increments and saturates at 255;
  - on clr_fault alone, clears to 0;
  - on cmd_err and clr_fault together, becomes 1.
- A parameter value of 0 disables that hold:
  - the timer loads 0;
  - busy is still shown while sw_busy is high;
  - fault_cnt still counts.
- Next state is computed from the next-cycle timer values and the current sw_busy, with priority fault > busy > link > idle:
  - fault_tmr_next != 0 → 3;
  - else sw_busy | busy_tmr_next != 0 → 2;
  - else link_tmr_next != 0 → 1;
  - else 0.
- state is registered. An input sampled at edge n is reflected in state from edge n onward, i.e. visible in cycle n+1: one-cycle latency, with no extra pipeline stage.
- state_chg is registered as (state_next != state) and is therefore coincident with the first cycle of the new state value.
- No other outputs are combinational from inputs.

Test Plan:
1. Drive state=3 and fault_cnt=5, then assert Rst between clock edges → state=0, fault_cnt=0 and state_chg=0 before the next edge. Deassert Rst → prescaler restarts from 0.
2. TICK_DIV=4, LINK_TIMEOUT=5: one rx_activity pulse → state=1 in the next cycle with state_chg=1 for that cycle. state returns to 0 after the 5th subsequent tick (17–20 cycles later), with a second state_chg pulse.
3. BUSY_HOLD=2, no link activity: sw_busy high for 3 cycles → state=2 during those cycles, held through 2 ticks after the fall, then 0. Repeat with link_tmr active → the fallback is 1.
4. While sw_busy is high, pulse cmd_err → state=3 (fault outranks busy). Then pulse clr_fault → state=2 in the next cycle and fault_cnt=0.
5. 300 cmd_err pulses → fault_cnt=255 with no wrap. Then cmd_err and clr_fault in the same cycle → fault_cnt=1, fault_tmr=FAULT_HOLD, state=3.
6. Set link_tmr=1 and pulse rx_activity in the same cycle as tick → link_tmr=LINK_TIMEOUT (load wins), state stays 1, and no state_chg pulse.

Source files
------------

// File: rtl/status_state_gen.sv
// Priority-encoded LED status generator: turns event pulses and the actuator
// busy level into a stable 2-bit status, stretched by tick-based hold timers.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | nothing to report
// ST_LINK  | UART byte or command seen within LINK_TIMEOUT
// ST_BUSY  | actuator busy, or within BUSY_HOLD after it
// ST_FAULT | command error within FAULT_HOLD, not cleared
module status_state_gen #(
    parameter logic [15:0] TICK_DIV     = 16'd50000,
    parameter logic [11:0] LINK_TIMEOUT = 12'd2000,
    parameter logic [11:0] BUSY_HOLD    = 12'd200,
    parameter logic [11:0] FAULT_HOLD   = 12'd3000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       rx_activity,
    input  logic       cmd_ok,
    input  logic       cmd_err,
    input  logic       sw_busy,
    input  logic       clr_fault,
    output logic [1:0] state,
    output logic [7:0] fault_cnt,
    output logic       state_chg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINK  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 16'd1);

    logic [15:0] prescaler;
    logic        tick;
    logic [11:0] link_tmr, link_tmr_nxt;
    logic [11:0] busy_tmr, busy_tmr_nxt;
    logic [11:0] fault_tmr, fault_tmr_nxt;
    logic [7:0]  fault_cnt_nxt;
    state_t      state_q, state_nxt;

    assign tick = (prescaler == PRESC_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            prescaler <= 16'd0;
        end else if (tick) begin
            prescaler <= 16'd0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Load always beats the tick decrement, so a retrigger never loses a count.
    always_comb begin
        link_tmr_nxt = link_tmr;
        if (rx_activity || cmd_ok || cmd_err) begin
            link_tmr_nxt = LINK_TIMEOUT;
        end else if (tick && (link_tmr != 12'd0)) begin
            link_tmr_nxt = link_tmr - 12'd1;
        end
    end

    always_comb begin
        busy_tmr_nxt = busy_tmr;
        if (sw_busy) begin
            busy_tmr_nxt = BUSY_HOLD;
        end else if (tick && (busy_tmr != 12'd0)) begin
            busy_tmr_nxt = busy_tmr - 12'd1;
        end
    end

    always_comb begin
        fault_tmr_nxt = fault_tmr;
        if (cmd_err) begin
            fault_tmr_nxt = FAULT_HOLD;
        end else if (clr_fault) begin
            fault_tmr_nxt = 12'd0;
        end else if (tick && (fault_tmr != 12'd0)) begin
            fault_tmr_nxt = fault_tmr - 12'd1;
        end
    end

    // A simultaneous error and clear leaves exactly the new error counted.
    always_comb begin
        fault_cnt_nxt = fault_cnt;
        if (cmd_err && clr_fault) begin
            fault_cnt_nxt = 8'd1;
        end else if (cmd_err) begin
            if (fault_cnt != 8'hFF) begin
                fault_cnt_nxt = fault_cnt + 8'd1;
            end
        end else if (clr_fault) begin
            fault_cnt_nxt = 8'd0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            link_tmr  <= 12'd0;
            busy_tmr  <= 12'd0;
            fault_tmr <= 12'd0;
            fault_cnt <= 8'd0;
        end else begin
            link_tmr  <= link_tmr_nxt;
            busy_tmr  <= busy_tmr_nxt;
            fault_tmr <= fault_tmr_nxt;
            fault_cnt <= fault_cnt_nxt;
        end
    end

    // Next state looks at next-cycle timer values so events show with one cycle of latency.
    always_comb begin
        state_nxt = ST_IDLE;
        if (fault_tmr_nxt != 12'd0) begin
            state_nxt = ST_FAULT;
        end else if (sw_busy || (busy_tmr_nxt != 12'd0)) begin
            state_nxt = ST_BUSY;
        end else if (link_tmr_nxt != 12'd0) begin
            state_nxt = ST_LINK;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            state_chg <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            state_chg <= (state_nxt != state_q);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_status_state_gen.sv
// Directed bench for status_state_gen with short timers; every step is
// checked with an immediate assertion against hand-computed values.
module tb_status_state_gen;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       rx_activity = 1'b0;
    logic       cmd_ok = 1'b0;
    logic       cmd_err = 1'b0;
    logic       sw_busy = 1'b0;
    logic       clr_fault = 1'b0;
    logic [1:0] state;
    logic [7:0] fault_cnt;
    logic       state_chg;

    int passed = 0;
    int total  = 0;

    status_state_gen #(
        .TICK_DIV    (16'd4),
        .LINK_TIMEOUT(12'd5),
        .BUSY_HOLD   (12'd2),
        .FAULT_HOLD  (12'd6)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .rx_activity(rx_activity),
        .cmd_ok     (cmd_ok),
        .cmd_err    (cmd_err),
        .sw_busy    (sw_busy),
        .clr_fault  (clr_fault),
        .state      (state),
        .fault_cnt  (fault_cnt),
        .state_chg  (state_chg)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Leaves the bench at the negedge of release; the next posedge is p1,
    // so the prescaler reads k mod 4 after pk and ticks land on p4, p8, ...
    task automatic do_reset();
        @(negedge Clk);
        #2 Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        // Test 1: build up fault state, then asynchronous reset mid-cycle.
        cyc(2);
        Rst = 1'b0;
        repeat (5) begin
            cmd_err = 1'b1;
            cyc(1);
            cmd_err = 1'b0;
            cyc(1);
        end
        chk("pre_rst_state", 32'(state), 32'd3);
        chk("pre_rst_cnt", 32'(fault_cnt), 32'd5);
        #2 Rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_cnt", 32'(fault_cnt), 32'd0);
        chk("async_rst_chg", 32'(state_chg), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        chk("presc_restart", 32'(dut.prescaler), 32'd0);

        // Test 2: single rx pulse, link shown until the 5th tick (p20).
        rx_activity = 1'b1;
        cyc(1);
        rx_activity = 1'b0;
        chk("presc_after_p1", 32'(dut.prescaler), 32'd1);
        chk("link_on_state", 32'(state), 32'd1);
        chk("link_on_chg", 32'(state_chg), 32'd1);
        cyc(1);
        chk("link_hold_chg", 32'(state_chg), 32'd0);
        cyc(17);
        chk("link_p19_state", 32'(state), 32'd1);
        cyc(1);
        chk("link_off_state", 32'(state), 32'd0);
        chk("link_off_chg", 32'(state_chg), 32'd1);

        // Test 3a: busy for p1..p3, held through ticks at p4 and p8.
        do_reset();
        sw_busy = 1'b1;
        cyc(1);
        chk("busy_on_state", 32'(state), 32'd2);
        chk("busy_on_chg", 32'(state_chg), 32'd1);
        cyc(2);
        sw_busy = 1'b0;
        chk("busy_p3_state", 32'(state), 32'd2);
        cyc(4);
        chk("busy_hold_p7", 32'(state), 32'd2);
        cyc(1);
        chk("busy_off_p8", 32'(state), 32'd0);
        chk("busy_off_chg", 32'(state_chg), 32'd1);

        // Test 3b: same with link active, fallback is link.
        do_reset();
        sw_busy = 1'b1;
        rx_activity = 1'b1;
        cyc(1);
        rx_activity = 1'b0;
        chk("busy_link_on", 32'(state), 32'd2);
        cyc(2);
        sw_busy = 1'b0;
        cyc(5);
        chk("busy_fallback_link", 32'(state), 32'd1);
        chk("busy_fallback_chg", 32'(state_chg), 32'd1);
        chk("busy_fallback_ltmr", 32'(dut.link_tmr), 32'd3);

        // Test 4: fault outranks busy, clear falls back to busy.
        do_reset();
        sw_busy = 1'b1;
        cyc(1);
        cmd_err = 1'b1;
        cyc(1);
        cmd_err = 1'b0;
        chk("fault_over_busy", 32'(state), 32'd3);
        chk("fault_over_busy_chg", 32'(state_chg), 32'd1);
        chk("fault_cnt_1", 32'(fault_cnt), 32'd1);
        clr_fault = 1'b1;
        cyc(1);
        clr_fault = 1'b0;
        chk("clr_to_busy", 32'(state), 32'd2);
        chk("clr_cnt", 32'(fault_cnt), 32'd0);
        sw_busy = 1'b0;

        // Test 5: saturation, then error and clear together.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cmd_err = 1'b1;
            cyc(1);
            cmd_err = 1'b0;
            cyc(1);
            if (i == 253) chk("cnt_254", 32'(fault_cnt), 32'd254);
        end
        chk("cnt_sat", 32'(fault_cnt), 32'd255);
        chk("sat_state", 32'(state), 32'd3);
        cmd_err = 1'b1;
        clr_fault = 1'b1;
        cyc(1);
        cmd_err = 1'b0;
        clr_fault = 1'b0;
        chk("err_clr_cnt", 32'(fault_cnt), 32'd1);
        chk("err_clr_ftmr", 32'(dut.fault_tmr), 32'd6);
        chk("err_clr_state", 32'(state), 32'd3);

        // Test 6: rx lands on the tick that would expire link_tmr=1.
        do_reset();
        rx_activity = 1'b1;
        cyc(1);
        rx_activity = 1'b0;
        cyc(18);
        chk("pre_ltmr_1", 32'(dut.link_tmr), 32'd1);
        chk("pre_tick", 32'(dut.tick), 32'd1);
        rx_activity = 1'b1;
        cyc(1);
        rx_activity = 1'b0;
        chk("reload_ltmr", 32'(dut.link_tmr), 32'd5);
        chk("reload_state", 32'(state), 32'd1);
        chk("reload_no_chg", 32'(state_chg), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
